digitizer_sync_fifo: RTL and testbench
======================================

# digitizer_sync_fifo

Parametrised single-clock FIFO for the digitizer datapath. It buffers sample and command words between blocks that share one clock domain, and replaces fixed 32x64 FIFO instances. Width and depth are generic. The block adds:
- standard or first-word-fall-through (FWFT) read mode;
- programmable almost-full and almost-empty thresholds;
- an occupancy count;
- sticky overflow and underflow error flags;
- a synchronous flush.

## Interface
Parameters:
- WIDTH, 32, data word width in bits (1..128)
- DEPTH, 64, capacity in words; power of two, 4..4096
- FWFT, 0, read mode: 0 = standard (Q valid one cycle after RE), 1 = first-word-fall-through
- AFULL_TH, 60, AFULL asserts when COUNT >= AFULL_TH (1..DEPTH)
- AEMPTY_TH, 4, AEMPTY asserts when COUNT <= AEMPTY_TH (0..DEPTH-1)

Ports (CW = clog2(DEPTH)+1):
- CLK  in  1  single clock; all logic on its rising edge
- RESET  in  1  reset, asynchronous, active-high; deassertion must be synchronised to CLK externally
- DATA  in  WIDTH  write data
- WE  in  1  write request, active-high
- RE  in  1  read request (standard mode) or pop (FWFT mode), active-high
- FLUSH  in  1  synchronous clear of contents, active-high
- CLR_ERR  in  1  clears OVERFLOW and UNDERFLOW, active-high
- Q  out  WIDTH  read data
- DVLD  out  1  Q holds valid data this cycle
- FULL  out  1  COUNT == DEPTH
- EMPTY  out  1  no word readable
- AFULL  out  1  almost full
- AEMPTY  out  1  almost empty
- COUNT  out  CW  occupancy, 0..DEPTH
- OVERFLOW  out  1  sticky: a write was attempted while FULL
- UNDERFLOW  out  1  sticky: a read was attempted while EMPTY

## Operation
Reset values (RESET high, immediate):
- Q = 0, DVLD = 0, COUNT = 0
- EMPTY = 1, FULL = 0, AEMPTY = 1, AFULL = 0
- OVERFLOW = 0, UNDERFLOW = 0
- Pointers cleared.

Storage and flags:
- Dual-port RAM of DEPTH x WIDTH.
- Read and write pointers are clog2(DEPTH)+1 bits wide; the MSB differs on wrap. Wrap-around is seamless.
- Accepted write: WE && !FULL. Accepted read: RE && !EMPTY. FULL and EMPTY are sampled as registered at the start of the cycle.
- Write while FULL: data dropped, OVERFLOW set. Read while EMPTY: no pop, UNDERFLOW set.
- CLR_ERR clears both error flags. If CLR_ERR coincides with a new error, the set wins.
- COUNT += accepted write, -= accepted read. A simultaneous accepted write and read leaves COUNT unchanged.
- When FULL, a simultaneous WE and RE accepts the read and rejects the write (OVERFLOW set). When EMPTY, a simultaneous WE and RE accepts the write and rejects the read (UNDERFLOW set).
- FULL, EMPTY, AFULL and AEMPTY are registered and consistent with the COUNT value of the same cycle.

FLUSH:
- Next cycle: COUNT = 0, EMPTY = 1, FULL = 0, DVLD = 0, Q = 0.
- Error flags are kept.
- WE and RE in the flush cycle are ignored.
- FLUSH has priority over everything except RESET.

Standard mode (FWFT = 0):
- Accepted read at edge k: Q = head word and DVLD = 1 after edge k.
- Otherwise DVLD = 0 and Q holds its last value.

FWFT mode (FWFT = 1):
- Head word sits in an output register. DVLD = !EMPTY, and Q is the head whenever DVLD = 1.
- RE pops the head; the next word appears on the following cycle.
- COUNT includes the output-register word.
- When empty, Q holds its last value.

## Timing
- Standard mode:
  - Write-to-EMPTY deassert: write accepted at edge k gives EMPTY = 0 after edge k.
  - Read latency: 1 cycle from RE to Q/DVLD.
- FWFT mode:
  - Write into an empty FIFO at edge k gives Q valid and EMPTY = 0 after edge k+1 (latency 2).
  - Back-to-back RE pops one word per cycle with no bubbles while COUNT >= 2.
- FULL asserts after the edge at which the DEPTH-th word is accepted. It deasserts after the first accepted read.
- Sustained throughput: one write and one read per cycle.
- RESET mid-operation: all outputs return to reset values immediately; contents are lost.

## Test plan
- Reset, then fill (standard mode, DEPTH = 64): write 0..63 in consecutive cycles. Required: FULL = 1 and COUNT = 64 after the 64th edge; AFULL rises when COUNT reaches 60. A 65th write sets OVERFLOW and leaves COUNT = 64.
- Drain: RE held for 66 cycles. Required: Q = 0..63 in order, each with DVLD = 1 one cycle after its RE. EMPTY rises after the 64th read edge; the extra reads set UNDERFLOW. CLR_ERR then clears both flags.
- Wrap-around: 200 cycles of random WE/RE with COUNT kept between 1 and 63. Required: the scoreboard matches the data order and COUNT matches the model every cycle.
- FWFT = 1: a single write of 0xA5A5A5A5 into an empty FIFO. Required: Q = 0xA5A5A5A5 with DVLD = 1 two edges later. One RE gives EMPTY = 1 on the next cycle.
- Simultaneous WE and RE when full: COUNT 64 -> 63 with OVERFLOW = 1. When empty: COUNT 0 -> 1 with UNDERFLOW = 1.
- FLUSH at COUNT = 30 with WE = 1: next cycle COUNT = 0 and EMPTY = 1. Asynchronous RESET mid-burst: all outputs at reset values before the next edge.

Source files
------------

// File: rtl/digitizer_sync_fifo.sv
// Single-clock FIFO for the digitizer datapath: generic width/depth, standard or
// first-word-fall-through read, programmable thresholds, sticky error flags and flush.
module digitizer_sync_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 64,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 60,
    parameter int AEMPTY_TH = 4,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA,
    input  logic             WE,
    input  logic             RE,
    input  logic             FLUSH,
    input  logic             CLR_ERR,
    output logic [WIDTH-1:0] Q,
    output logic             DVLD,
    output logic             FULL,
    output logic             EMPTY,
    output logic             AFULL,
    output logic             AEMPTY,
    output logic [CW-1:0]    COUNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] q_reg;
    logic             dvld_reg;
    logic             dvld_next;
    logic             full_reg;
    logic             empty_reg;
    logic             empty_next;
    logic             afull_reg;
    logic             aempty_reg;
    logic             overflow_reg;
    logic             underflow_reg;

    logic             wr_acc;
    logic             rd_acc;
    logic             wr_err;
    logic             rd_err;
    logic             load;

    // Flags are the registered values from the previous edge; flush masks both requests.
    assign wr_acc = WE && !full_reg  && !FLUSH;
    assign rd_acc = RE && !empty_reg && !FLUSH;
    assign wr_err = WE &&  full_reg  && !FLUSH;
    assign rd_err = RE &&  empty_reg && !FLUSH;

    assign count_next = count_reg + CW'(wr_acc) - CW'(rd_acc);

    generate
        if (FWFT != 0) begin : g_fwft
            // Words still in RAM (excluding the output register); never reads a slot being written.
            logic [CW-1:0] ram_cnt;
            assign ram_cnt    = wr_ptr_reg - rd_ptr_reg;
            assign load       = (!dvld_reg || rd_acc) && (ram_cnt != '0) && !FLUSH;
            assign dvld_next  = load || (dvld_reg && !rd_acc);
            assign empty_next = !dvld_next;
        end else begin : g_std
            assign load       = rd_acc;
            assign dvld_next  = rd_acc;
            assign empty_next = (count_next == '0);
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr_reg[AW-1:0]] <= DATA;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            q_reg         <= '0;
            dvld_reg      <= 1'b0;
            full_reg      <= 1'b0;
            empty_reg     <= 1'b1;
            afull_reg     <= 1'b0;
            aempty_reg    <= 1'b1;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            // A new error in the same cycle as CLR_ERR keeps the flag set.
            if (wr_err) begin
                overflow_reg <= 1'b1;
            end else if (CLR_ERR) begin
                overflow_reg <= 1'b0;
            end
            if (rd_err) begin
                underflow_reg <= 1'b1;
            end else if (CLR_ERR) begin
                underflow_reg <= 1'b0;
            end

            if (FLUSH) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
                q_reg      <= '0;
                dvld_reg   <= 1'b0;
                full_reg   <= 1'b0;
                empty_reg  <= 1'b1;
                afull_reg  <= 1'b0;
                aempty_reg <= 1'b1;
            end else begin
                wr_ptr_reg <= wr_ptr_reg + CW'(wr_acc);
                rd_ptr_reg <= rd_ptr_reg + CW'(load);
                count_reg  <= count_next;
                dvld_reg   <= dvld_next;
                full_reg   <= (count_next == CW'(DEPTH));
                empty_reg  <= empty_next;
                afull_reg  <= (count_next >= CW'(AFULL_TH));
                aempty_reg <= (count_next <= CW'(AEMPTY_TH));
                if (load) begin
                    q_reg <= mem[rd_ptr_reg[AW-1:0]];
                end
            end
        end
    end

    assign Q         = q_reg;
    assign DVLD      = dvld_reg;
    assign FULL      = full_reg;
    assign EMPTY     = empty_reg;
    assign AFULL     = afull_reg;
    assign AEMPTY    = aempty_reg;
    assign COUNT     = count_reg;
    assign OVERFLOW  = overflow_reg;
    assign UNDERFLOW = underflow_reg;

endmodule

// File: tb/tb_digitizer_sync_fifo.sv
// Bench for digitizer_sync_fifo: standard-mode instance checked cycle by cycle against a
// queue-based scoreboard, plus a first-word-fall-through instance for latency checks.
module tb_digitizer_sync_fifo;

    localparam int W  = 32;
    localparam int D  = 64;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;

    logic [W-1:0]  data;
    logic          we, re, flush, clr_err;
    logic [W-1:0]  q;
    logic          dvld, full, empty, afull, aempty, overflow, underflow;
    logic [CW-1:0] count;

    logic [W-1:0]  f_data;
    logic          f_we, f_re, f_flush, f_clr;
    logic [W-1:0]  f_q;
    logic          f_dvld, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [CW-1:0] f_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [W-1:0]  sb[$];
    int            m_cnt;
    logic [W-1:0]  m_q;
    logic          m_dvld, m_ovf, m_udf;
    logic [W-1:0]  fq[$];

    always #5 clk = ~clk;

    digitizer_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AFULL_TH(60), .AEMPTY_TH(4)) dut (
        .CLK(clk), .RESET(rst), .DATA(data), .WE(we), .RE(re), .FLUSH(flush),
        .CLR_ERR(clr_err), .Q(q), .DVLD(dvld), .FULL(full), .EMPTY(empty),
        .AFULL(afull), .AEMPTY(aempty), .COUNT(count), .OVERFLOW(overflow),
        .UNDERFLOW(underflow)
    );

    digitizer_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AFULL_TH(60), .AEMPTY_TH(4)) dut_f (
        .CLK(clk), .RESET(rst), .DATA(f_data), .WE(f_we), .RE(f_re), .FLUSH(f_flush),
        .CLR_ERR(f_clr), .Q(f_q), .DVLD(f_dvld), .FULL(f_full), .EMPTY(f_empty),
        .AFULL(f_afull), .AEMPTY(f_aempty), .COUNT(f_count), .OVERFLOW(f_ovf),
        .UNDERFLOW(f_udf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt  = 0;
        m_q    = '0;
        m_dvld = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic check_std_outputs(input string where);
        check({where, ".count"},  64'(count),     64'(m_cnt));
        check({where, ".full"},   64'(full),      64'(m_cnt == D));
        check({where, ".empty"},  64'(empty),     64'(m_cnt == 0));
        check({where, ".afull"},  64'(afull),     64'(m_cnt >= 60));
        check({where, ".aempty"}, 64'(aempty),    64'(m_cnt <= 4));
        check({where, ".ovf"},    64'(overflow),  64'(m_ovf));
        check({where, ".udf"},    64'(underflow), 64'(m_udf));
        check({where, ".dvld"},   64'(dvld),      64'(m_dvld));
        check({where, ".q"},      64'(q),         64'(m_q));
    endtask

    // One clock of stimulus on the standard instance; the model advances with the edge.
    task automatic cycle(input logic w, input logic r, input logic fl, input logic clr,
                         input logic [W-1:0] d);
        logic full_m, empty_m, wa, ra;
        we = w; re = r; flush = fl; clr_err = clr; data = d;
        full_m  = (m_cnt == D);
        empty_m = (m_cnt == 0);
        @(posedge clk);
        #1;
        if (w && full_m && !fl)       m_ovf = 1'b1;
        else if (clr)                 m_ovf = 1'b0;
        if (r && empty_m && !fl)      m_udf = 1'b1;
        else if (clr)                 m_udf = 1'b0;
        if (fl) begin
            sb.delete();
            m_cnt  = 0;
            m_q    = '0;
            m_dvld = 1'b0;
        end else begin
            wa = w && !full_m;
            ra = r && !empty_m;
            if (ra) m_q = sb.pop_front();
            m_dvld = ra;
            if (wa) sb.push_back(d);
            m_cnt = m_cnt + int'(wa) - int'(ra);
        end
        $display("txn we=%0b re=%0b fl=%0b clr=%0b d=%08h -> count=%0d dvld=%0b q=%08h",
                 w, r, fl, clr, d, count, dvld, q);
        check_std_outputs("std");
        we = 1'b0; re = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    task automatic check_reset_values(input string where);
        check({where, ".q"},      64'(q),         64'h0);
        check({where, ".dvld"},   64'(dvld),      64'h0);
        check({where, ".count"},  64'(count),     64'h0);
        check({where, ".empty"},  64'(empty),     64'h1);
        check({where, ".full"},   64'(full),      64'h0);
        check({where, ".aempty"}, 64'(aempty),    64'h1);
        check({where, ".afull"},  64'(afull),     64'h0);
        check({where, ".ovf"},    64'(overflow),  64'h0);
        check({where, ".udf"},    64'(underflow), 64'h0);
        check({where, ".f_q"},    64'(f_q),       64'h0);
        check({where, ".f_dvld"}, 64'(f_dvld),    64'h0);
        check({where, ".f_cnt"},  64'(f_count),   64'h0);
        check({where, ".f_empty"},64'(f_empty),   64'h1);
        check({where, ".f_full"}, 64'(f_full),    64'h0);
        check({where, ".f_aemp"}, 64'(f_aempty),  64'h1);
        check({where, ".f_afull"},64'(f_afull),   64'h0);
        check({where, ".f_ovf"},  64'(f_ovf),     64'h0);
        check({where, ".f_udf"},  64'(f_udf),     64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        we = 0; re = 0; flush = 0; clr_err = 0; data = '0;
        f_we = 0; f_re = 0; f_flush = 0; f_clr = 0; f_data = '0;
        model_reset();
        #3;
        check_reset_values("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Fill 0..63, then one write too many
        for (int i = 0; i < D; i++) cycle(1, 0, 0, 0, W'(i));
        cycle(1, 0, 0, 0, 32'hDEAD_BEEF);

        // Drain with two extra reads
        for (int i = 0; i < D + 2; i++) cycle(0, 1, 0, 0, '0);
        cycle(0, 0, 0, 1, '0);

        // Random traffic with wrap-around, occupancy held in 1..63
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, W'(100 + i));
        for (int i = 0; i < 200; i++) begin
            logic w, r;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (m_cnt >= 63) w = 1'b0;
            if (m_cnt <= 1)  r = 1'b0;
            cycle(w, r, 0, 0, $urandom);
        end

        // Simultaneous WE/RE when full, then when empty
        while (m_cnt < D) cycle(1, 0, 0, 0, $urandom);
        cycle(1, 1, 0, 0, 32'h1234_5678);
        check("full_wr_rd.count", 64'(count), 64'd63);
        cycle(0, 0, 0, 1, '0);
        while (m_cnt > 0) cycle(0, 1, 0, 0, '0);
        cycle(1, 1, 0, 0, 32'h8765_4321);
        check("empty_wr_rd.count", 64'(count), 64'd1);
        check("empty_wr_rd.udf",   64'(underflow), 64'd1);
        cycle(0, 0, 0, 1, '0);

        // Flush at COUNT = 30 with a write in the same cycle
        while (m_cnt < 30) cycle(1, 0, 0, 0, $urandom);
        cycle(1, 0, 1, 0, 32'hFFFF_0000);
        check("flush.count", 64'(count), 64'd0);
        cycle(1, 0, 0, 0, 32'h0BAD_F00D);
        cycle(0, 1, 0, 0, '0);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 8; i++) cycle(1, i[0], 0, 0, W'(i + 500));
        #2 rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // FWFT: single word has two-edge latency, one pop empties it
        f_we = 1'b1; f_data = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        f_we = 1'b0;
        check("fwft.k.dvld",   64'(f_dvld),  64'd0);
        check("fwft.k.empty",  64'(f_empty), 64'd1);
        check("fwft.k.count",  64'(f_count), 64'd1);
        @(posedge clk); #1;
        check("fwft.k1.dvld",  64'(f_dvld),  64'd1);
        check("fwft.k1.q",     64'(f_q),     64'hA5A5_A5A5);
        check("fwft.k1.empty", 64'(f_empty), 64'd0);
        f_re = 1'b1;
        @(posedge clk); #1;
        f_re = 1'b0;
        check("fwft.pop.empty", 64'(f_empty), 64'd1);
        check("fwft.pop.dvld",  64'(f_dvld),  64'd0);
        check("fwft.pop.count", 64'(f_count), 64'd0);
        check("fwft.pop.q",     64'(f_q),     64'hA5A5_A5A5);
        check("fwft.pop.udf",   64'(f_udf),   64'd0);

        // FWFT back-to-back pops without bubbles
        for (int i = 0; i < 3; i++) begin
            f_we = 1'b1; f_data = W'(32'h10 + i);
            fq.push_back(f_data);
            @(posedge clk); #1;
        end
        f_we = 1'b0;
        @(posedge clk); #1;
        check("fwft.b2b.count", 64'(f_count), 64'd3);
        f_re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] e;
            e = fq.pop_front();
            $display("txn fwft pop %0d -> q=%08h dvld=%0b", i, f_q, f_dvld);
            check("fwft.b2b.dvld", 64'(f_dvld), 64'd1);
            check("fwft.b2b.q",    64'(f_q),    64'(e));
            @(posedge clk); #1;
        end
        f_re = 1'b0;
        check("fwft.b2b.empty", 64'(f_empty), 64'd1);
        check("fwft.b2b.cnt0",  64'(f_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
